// File: rtl/uart_frame_tx.sv
// Buffered UART frame transmitter: a word FIFO feeding an 8N1 serializer that sends SOF, payload MSB first, EOF.
// Define UART_FRAME_CKSUM_EN to insert an XOR checksum byte between the payload and EOF.
module uart_frame_tx #(
  parameter int         CLK_FREQ   = 25000000,
  parameter int         BAUD       = 115200,
  parameter int         WORD_W     = 32,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SOF        = 8'hF5,
  parameter logic [7:0] EOF        = 8'hFA
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WORD_W-1:0]             data,
  input  logic                          valid,
  output logic                          ready,
  output logic                          ftdi_rxd,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int NBYTES       = WORD_W / 8;
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int LVL_W        = AW + 1;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int BIDX_W       = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [2:0] {
    F_IDLE, F_SOF, F_DATA, F_EOF
`ifdef UART_FRAME_CKSUM_EN
    , F_CKSUM
`endif
  } fstate_t;

  typedef enum logic [1:0] {B_START, B_DATA, B_STOP} bstate_t;

`ifdef UART_FRAME_CKSUM_EN
  function automatic logic [7:0] f_cksum(input logic [WORD_W-1:0] w);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < NBYTES; i++) acc = acc ^ w[i*8 +: 8];
    return acc;
  endfunction
`endif

  logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_ready;

  fstate_t           r_fstate;
  bstate_t           r_bstate;
  logic [CNT_W-1:0]  r_clk_cnt;
  logic [2:0]        r_bit_cnt;
  logic [BIDX_W-1:0] r_byte_idx;
  logic [WORD_W-1:0] r_frame;
`ifdef UART_FRAME_CKSUM_EN
  logic [7:0]        r_cksum;
`endif

  logic              r_rxd;
  logic              r_busy;
  logic              r_end_p0;
  logic              r_frame_done;

  logic              w_push;
  logic              w_pop;
  logic              w_bit_end;
  logic              w_stop_end;
  logic              w_frame_end;
  logic              w_byte_adv;
  logic [LVL_W-1:0]  w_level_nxt;
  logic [7:0]        w_byte;
  logic              w_line;

  assign w_push      = valid && r_ready;
  assign w_bit_end   = (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign w_stop_end  = (r_fstate != F_IDLE) && (r_bstate == B_STOP) && w_bit_end;
  assign w_frame_end = (r_fstate == F_EOF) && w_stop_end;
  assign w_byte_adv  = (r_fstate == F_DATA) && w_stop_end;
  assign w_pop       = (r_level != '0) && ((r_fstate == F_IDLE) || w_frame_end);

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)      w_level_nxt = r_level + 1'b1;
    else if (!w_push && w_pop) w_level_nxt = r_level - 1'b1;
  end

  // Current byte is chosen by frame state; payload leaves MSB first via the shifting frame register.
  always_comb begin
    case (r_fstate)
      F_DATA:  w_byte = r_frame[WORD_W-1 -: 8];
      F_EOF:   w_byte = EOF;
`ifdef UART_FRAME_CKSUM_EN
      F_CKSUM: w_byte = r_cksum;
`endif
      default: w_byte = SOF;
    endcase
    w_line = 1'b1;
    if (r_fstate != F_IDLE) begin
      case (r_bstate)
        B_START: w_line = 1'b0;
        B_DATA:  w_line = w_byte[r_bit_cnt];
        default: w_line = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data;
    if (w_pop) begin
      r_frame <= r_mem[r_rd_ptr];
`ifdef UART_FRAME_CKSUM_EN
      r_cksum <= f_cksum(r_mem[r_rd_ptr]);
`endif
    end else if (w_byte_adv) begin
      r_frame <= r_frame << 8;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_ready      <= 1'b0;
      r_fstate     <= F_IDLE;
      r_bstate     <= B_START;
      r_clk_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_byte_idx   <= '0;
      r_rxd        <= 1'b1;
      r_busy       <= 1'b0;
      r_end_p0     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_level <= w_level_nxt;
      r_ready <= (w_level_nxt != LVL_W'(FIFO_DEPTH));
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

      // Line, busy and the end-of-frame flag all trail the sequencer state by one register stage.
      r_rxd        <= w_line;
      r_busy       <= (r_fstate != F_IDLE);
      r_end_p0     <= w_frame_end;
      r_frame_done <= r_end_p0;

      if (r_fstate != F_IDLE) begin
        if (w_bit_end) begin
          r_clk_cnt <= '0;
          case (r_bstate)
            B_START: begin
              r_bstate  <= B_DATA;
              r_bit_cnt <= '0;
            end
            B_DATA: begin
              if (r_bit_cnt == 3'd7) r_bstate <= B_STOP;
              else                   r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            default: r_bstate <= B_START;
          endcase
        end else begin
          r_clk_cnt <= r_clk_cnt + 1'b1;
        end
      end

      if (w_pop) begin
        r_fstate <= F_SOF;
      end else if (w_stop_end) begin
        case (r_fstate)
          F_SOF: begin
            r_fstate   <= F_DATA;
            r_byte_idx <= BIDX_W'(NBYTES - 1);
          end
          F_DATA: begin
            if (r_byte_idx == '0) begin
`ifdef UART_FRAME_CKSUM_EN
              r_fstate <= F_CKSUM;
`else
              r_fstate <= F_EOF;
`endif
            end else begin
              r_byte_idx <= r_byte_idx - 1'b1;
            end
          end
`ifdef UART_FRAME_CKSUM_EN
          F_CKSUM: r_fstate <= F_EOF;
`endif
          default: r_fstate <= F_IDLE;
        endcase
      end
    end
  end

  assign ready      = r_ready;
  assign ftdi_rxd   = r_rxd;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign level      = r_level;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx: three instances (32/8/128-bit words) at 16 clocks per bit, line decoded 8N1.
module tb_uart_frame_tx;

  localparam int CPB = 16;
`ifdef UART_FRAME_CKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int FRAME0 = (4 + 2 + CK) * 10 * CPB;
  localparam int FRAME1 = (1 + 2 + CK) * 10 * CPB;
  localparam int FRAME2 = (16 + 2 + CK) * 10 * CPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]  data0;
  logic [7:0]   data1;
  logic [127:0] data2;
  logic valid0, valid1, valid2;
  logic ready0, ready1, ready2;
  logic rxd0, rxd1, rxd2;
  logic busy0, busy1, busy2;
  logic done0, done1, done2;
  logic [2:0] level0, level1, level2;

  uart_frame_tx #(.CLK_FREQ(16), .BAUD(1), .WORD_W(32), .FIFO_DEPTH(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .data(data0), .valid(valid0), .ready(ready0),
    .ftdi_rxd(rxd0), .busy(busy0), .frame_done(done0), .level(level0));
  uart_frame_tx #(.CLK_FREQ(16), .BAUD(1), .WORD_W(8), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .data(data1), .valid(valid1), .ready(ready1),
    .ftdi_rxd(rxd1), .busy(busy1), .frame_done(done1), .level(level1));
  uart_frame_tx #(.CLK_FREQ(16), .BAUD(1), .WORD_W(128), .FIFO_DEPTH(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .data(data2), .valid(valid2), .ready(ready2),
    .ftdi_rxd(rxd2), .busy(busy2), .frame_done(done2), .level(level2));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  int rst_epoch = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  typedef struct { logic [7:0] v; bit sof; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int sof_t0[$];
  int done_t0[$];
  int done_cnt[3] = '{0, 0, 0};

  always @(negedge clk) begin
    if (done0) begin done_cnt[0]++; done_t0.push_back(cyc); end
    if (done1) done_cnt[1]++;
    if (done2) done_cnt[2]++;
  end

  function automatic logic line(input int d);
    case (d) 0: return rxd0; 1: return rxd1; default: return rxd2; endcase
  endfunction
  function automatic logic bsy(input int d);
    case (d) 0: return busy0; 1: return busy1; default: return busy2; endcase
  endfunction
  function automatic logic fdone(input int d);
    case (d) 0: return done0; 1: return done1; default: return done2; endcase
  endfunction
  function automatic logic [2:0] lvl(input int d);
    case (d) 0: return level0; 1: return level1; default: return level2; endcase
  endfunction
  function automatic logic rdy(input int d);
    case (d) 0: return ready0; 1: return ready1; default: return ready2; endcase
  endfunction
  function automatic int qsize(input int d);
    case (d) 0: return q0.size(); 1: return q1.size(); default: return q2.size(); endcase
  endfunction
  function automatic exp_t qpop(input int d);
    case (d) 0: return q0.pop_front(); 1: return q1.pop_front(); default: return q2.pop_front(); endcase
  endfunction

  task automatic qput(input int d, input exp_t e);
    case (d) 0: q0.push_back(e); 1: q1.push_back(e); default: q2.push_back(e); endcase
  endtask

  task automatic set_in(input int d, input logic [127:0] w, input logic v);
    case (d)
      0: begin data0 = w[31:0]; valid0 = v; end
      1: begin data1 = w[7:0];  valid1 = v; end
      default: begin data2 = w; valid2 = v; end
    endcase
  endtask

  // Expected line bytes for one accepted word
  task automatic sb_push(input int d, input logic [127:0] w);
    int nb;
    logic [7:0] ck;
    exp_t e;
    nb = (d == 0) ? 4 : ((d == 1) ? 1 : 16);
    ck = 8'h00;
    e.v = 8'hF5; e.sof = 1'b1; qput(d, e);
    for (int i = nb - 1; i >= 0; i--) begin
      e.v = w[i*8 +: 8]; e.sof = 1'b0; qput(d, e);
      ck = ck ^ e.v;
    end
`ifdef UART_FRAME_CKSUM_EN
    e.v = ck; e.sof = 1'b0; qput(d, e);
`endif
    e.v = 8'hFA; e.sof = 1'b0; qput(d, e);
  endtask

  // 8N1 decoder: detects the start bit, samples mid-bit, compares against the scoreboard
  task automatic mon(input int d);
    logic [7:0] b;
    logic st_mid, stp;
    int t0, ep, prev_t0;
    exp_t e;
    prev_t0 = -100000;
    forever begin
      @(negedge clk);
      if (rst_n && line(d) == 1'b0) begin
        t0 = cyc;
        ep = rst_epoch;
        repeat (CPB/2) @(negedge clk);
        st_mid = line(d);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = line(d);
        end
        repeat (CPB) @(negedge clk);
        stp = line(d);
        repeat (CPB/2 - 1) @(negedge clk);
        if (ep == rst_epoch) begin
          chk($sformatf("sb_has_entry%0d", d), qsize(d) != 0, 1);
          if (qsize(d) != 0) begin
            e = qpop(d);
            chk($sformatf("byte%0d", d), b, e.v);
            chk($sformatf("start_bit%0d", d), st_mid, 0);
            chk($sformatf("stop_bit%0d", d), stp, 1);
            if (e.sof) begin
              if (d == 0) sof_t0.push_back(t0);
            end else begin
              chk($sformatf("byte_gap%0d", d), t0 - prev_t0, 10*CPB);
            end
            prev_t0 = t0;
          end
        end
      end
    end
  endtask

  initial begin
    fork
      mon(0);
      mon(1);
      mon(2);
    join_none
  end

  // Called in the low phase; returns in the low phase after the accepting edge t
  task automatic push(input int d, input logic [127:0] w, output int t);
    bit acc;
    acc = 1'b0;
    set_in(d, w, 1'b1);
    for (int i = 0; i < 2000 && !acc; i++) begin
      acc = rdy(d);
      @(posedge clk);
      if (acc) sb_push(d, w);
      @(negedge clk);
    end
    set_in(d, w, 1'b0);
    t = cyc;
    chk("push_accept", acc, 1);
  endtask

  task automatic one_frame(input int d, input logic [127:0] w, input int frame_len);
    int t, s;
    bit ok;
    push(d, w, t);
    s = -1;
    for (int i = 0; i < 8; i++) begin
      if (line(d) == 1'b0) begin s = cyc; break; end
      @(negedge clk);
    end
    chk("sof_latency", s - t, 2);
    chk("busy_at_sof", bsy(d), 1);
    chk("level_inflight", lvl(d), 0);
    ok = 1'b0;
    for (int i = 0; i < frame_len + 100; i++) begin
      @(negedge clk);
      if (fdone(d)) begin ok = 1'b1; break; end
    end
    chk("done_seen", ok, 1);
    if (ok) begin
      chk("done_latency", cyc - s, frame_len);
      chk("busy_at_done", bsy(d), 0);
      @(negedge clk);
      chk("done_pulse_width", fdone(d), 0);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_dones(input int base, input int want, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt[0] - base >= want) break;
    end
    @(negedge clk);
    chk("done_count", done_cnt[0] - base, want);
  endtask

  initial begin
    int t, t4, k, drop_at, n_sof, n_done;
    bit acc;
    valid0 = 0; valid1 = 0; valid2 = 0;
    data0 = '0; data1 = '0; data2 = '0;

    repeat (3) @(negedge clk);
    chk("rst_ready", ready0, 0);
    chk("rst_rxd", rxd0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_level", level0, 0);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", ready0, 0);
    @(negedge clk);
    chk("ready_after_edge", ready0, 1);

    // Single frame on the 32-bit instance
    one_frame(0, 128'hDEADBEEF, FRAME0);

    // Stream of eight words with valid held high
    n_sof = sof_t0.size();
    n_done = done_cnt[0];
    k = 0;
    drop_at = -1;
    valid0 = 1'b1;
    for (int c = 0; c < 20000 && k < 8; c++) begin
      data0 = 32'hA1B2C3D0 + k;
      acc = ready0;
      if (!ready0 && drop_at < 0) begin
        drop_at = k;
        chk("level_full", level0, 4);
      end
      @(posedge clk);
      if (acc) begin
        sb_push(0, 128'(32'hA1B2C3D0 + k));
        k++;
      end
      @(negedge clk);
    end
    valid0 = 1'b0;
    chk("ready_drop_after", drop_at, 5);
    chk("all_accepted", k, 8);
    wait_dones(n_done, 8, 9 * FRAME0);
    chk("sof_recorded", sof_t0.size() - n_sof, 8);
    if (sof_t0.size() >= n_sof + 8 && done_t0.size() >= n_done + 8) begin
      for (int i = 0; i < 8; i++) begin
        if (i > 0) chk("frame_contig", sof_t0[n_sof+i] - sof_t0[n_sof+i-1], FRAME0);
        chk("done_pos", done_t0[n_done+i] - sof_t0[n_sof+i], FRAME0);
      end
    end
    repeat (4) @(negedge clk);

    // Push on the same edge as the EOF pop with level 2
    n_done = done_cnt[0];
    push(0, 128'h11111111, t);
    push(0, 128'h22222222, t4);
    push(0, 128'h33333333, t4);
    while (cyc < t + 2 + FRAME0 - 2) @(negedge clk);
    chk("level_before_simul", level0, 2);
    push(0, 128'h44444444, t4);
    chk("simul_edge", t4, t + 2 + FRAME0 - 1);
    chk("level_simul", level0, 2);
    wait_dones(n_done, 4, 5 * FRAME0);
    repeat (4) @(negedge clk);

    // Reset during the start bit of payload byte 2
    push(0, 128'hDEADBEEF, t);
    while (cyc < t + 2 + 2*10*CPB + 5) @(negedge clk);
    chk("line_before_reset", rxd0, 0);
    n_done = done_cnt[0];
    #2;
    rst_n = 1'b0;
    rst_epoch++;
    #1 chk("rxd_async_reset", rxd0, 1);
    q0.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("post_rst_level", level0, 0);
    chk("post_rst_busy", busy0, 0);
    chk("post_rst_no_done", done_cnt[0] - n_done, 0);
    one_frame(0, 128'h01020304, FRAME0);

    // Narrow and wide word instances
    one_frame(1, 128'h5A, FRAME1);
    one_frame(2, 128'h0102030405060708090A0B0C0D0E0F10, FRAME2);

    repeat (20) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
